// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for the ID/EX boundary.
// Tracks the EX instruction plus DEPTH downstream result stages.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [2:0]        forward_a_o,
    output logic [2:0]        forward_b_o,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              rs_used;
        logic              rt_used;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } ex_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stg_t;

    ex_t              ex_q;
    ex_t              ex_d;
    stg_t             stg_q [1:DEPTH];
    logic [CNT_W-1:0] cnt_q;

    assign stall_o = id_valid_i & ex_q.valid & ex_q.memread & ex_q.regwrite
                   & (ex_q.rd != '0)
                   & ((id_rs_used_i & (id_rs_i == ex_q.rd))
                    | (id_rt_used_i & (id_rt_i == ex_q.rd)));

    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;
    assign stall_cnt_o  = cnt_q;

    // Stall and flush both inject a fully zeroed bubble into EX.
    always_comb begin
        ex_d = '0;
        if (!(stall_o || flush_i)) begin
            ex_d.valid    = id_valid_i;
            ex_d.rs       = id_rs_i;
            ex_d.rt       = id_rt_i;
            ex_d.rs_used  = id_rs_used_i;
            ex_d.rt_used  = id_rt_used_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            cnt_q <= '0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            ex_q              <= ex_d;
            stg_q[1].valid    <= ex_q.valid;
            stg_q[1].rd       <= ex_q.rd;
            stg_q[1].regwrite <= ex_q.regwrite;
            stg_q[1].memread  <= ex_q.memread;
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                stg_q[k] <= stg_q[k-1];
            end
            if (stall_o && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // First match scanning upward is the youngest producer.
    always_comb begin
        forward_a_o = '0;
        forward_b_o = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if ((forward_a_o == '0) && stg_q[k].valid && stg_q[k].regwrite
                && (stg_q[k].rd != '0) && (stg_q[k].rd == ex_q.rs)
                && ex_q.rs_used && ex_q.valid) begin
                forward_a_o = 3'(k);
            end
            if ((forward_b_o == '0) && stg_q[k].valid && stg_q[k].regwrite
                && (stg_q[k].rd != '0) && (stg_q[k].rd == ex_q.rt)
                && ex_q.rt_used && ex_q.valid) begin
                forward_b_o = 3'(k);
            end
        end
        // A load one stage ahead has no data yet; never select it.
        if ((forward_a_o == 3'd1) && stg_q[1].memread) begin
            forward_a_o = '0;
        end
        if ((forward_b_o == 3'd1) && stg_q[1].memread) begin
            forward_b_o = '0;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: vector table plus hand-written
// sequences for counter saturation and asynchronous reset.
module tb_fwd_hazard_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_rs_used_i;
    logic       id_rt_used_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       flush_i;

    logic [2:0]  fa, fb, fa_c, fb_c;
    logic        st, st_c, pcw, pcw_c, ifw, ifw_c;
    logic [15:0] cnt;
    logic [1:0]  cnt_c;

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i),
        .forward_a_o(fa), .forward_b_o(fb), .stall_o(st),
        .pc_write_o(pcw), .ifid_write_o(ifw), .stall_cnt_o(cnt)
    );

    fwd_hazard_ctrl #(.CNT_W(2)) dut_c (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i),
        .forward_a_o(fa_c), .forward_b_o(fb_c), .stall_o(st_c),
        .pc_write_o(pcw_c), .ifid_write_o(ifw_c), .stall_cnt_o(cnt_c)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       rsu, rtu;
        logic [4:0] rd;
        logic       rw, mr, fl;
        logic [2:0] fa, fb;
        logic       st;
        int         cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic rsu, input logic rtu, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic fl,
                                input logic [2:0] efa, input logic [2:0] efb,
                                input logic est, input int ecnt);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.rsu = rsu; r.rtu = rtu; r.rd = rd;
        r.rw = rw; r.mr = mr; r.fl = fl;
        r.fa = efa; r.fb = efb; r.st = est; r.cnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] efa, input logic [2:0] efb,
                           input logic est, input int ecnt);
        int ecnt_c;
        ecnt_c = (ecnt > 3) ? 3 : ecnt;
        chk({tag, " forward_a"}, 32'(fa), 32'(efa));
        chk({tag, " forward_b"}, 32'(fb), 32'(efb));
        chk({tag, " stall"}, 32'(st), 32'(est));
        chk({tag, " pc_write"}, 32'(pcw), 32'(!est));
        chk({tag, " ifid_write"}, 32'(ifw), 32'(!est));
        chk({tag, " stall_cnt"}, 32'(cnt), 32'(ecnt));
        chk({tag, " stall_cnt_w2"}, 32'(cnt_c), 32'(ecnt_c));
        chk({tag, " stall_w2"}, 32'(st_c), 32'(est));
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rsu, input logic rtu, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic fl);
        id_valid_i = v; id_rs_i = rs; id_rt_i = rt;
        id_rs_used_i = rsu; id_rt_used_i = rtu; id_rd_i = rd;
        id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rsu, input logic rtu, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        @(posedge clk_i);
        #1;
        set_id(v, rs, rt, rsu, rtu, rd, rw, mr, fl);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // add r3 ; sub r4,r3,r3 ; bubble
        vq.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // add r3 ; nop ; and r8,r3,r9 -> stage 2
        vq.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 3, 9, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        // add r3 ; add r3 ; use r3 -> youngest (stage 1)
        vq.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 3, 3, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        // write r0 ; read r0 -> no forwarding
        vq.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw r5 ; add r6,r5,r1 -> one stall, then stage 2
        vq.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1));
        // flushed add r7 ; use r7 -> select 0
        vq.push_back(mk(1, 1, 2, 1, 1, 7, 1, 0, 1, 0, 0, 0, 1));
        vq.push_back(mk(1, 7, 7, 1, 1, 12, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // lw r5 ; use r5 with flush in the stall cycle
        vq.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 1, 0, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));

        #1;
        chk_all("reset_hold", 0, 0, 0, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk_all("reset_after_edge", 0, 0, 0, 0);
        rst_i = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            issue(vq[i].v, vq[i].rs, vq[i].rt, vq[i].rsu, vq[i].rtu,
                  vq[i].rd, vq[i].rw, vq[i].mr, vq[i].fl);
            chk_all($sformatf("vec%0d", i), vq[i].fa, vq[i].fb, vq[i].st, vq[i].cnt);
        end

        // Five more load-use stalls: wide counter keeps counting, 2-bit holds at 3.
        for (int i = 0; i < 5; i++) begin
            issue(1, 1, 0, 1, 0, 5, 1, 1, 0);
            issue(1, 5, 1, 1, 1, 6, 1, 0, 0);
            chk($sformatf("sat%0d stall", i), 32'(st), 32'd1);
            issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("sat%0d stall_cnt", i), 32'(cnt), 32'(3 + i));
            chk($sformatf("sat%0d stall_cnt_w2", i), 32'(cnt_c), 32'd3);
        end

        // Build a state with live forwarding and stall, then reset mid-cycle.
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
        issue(1, 3, 0, 1, 0, 5, 1, 1, 0);
        issue(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk_all("pre_reset", 1, 0, 1, 7);
        #2;
        rst_i = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0);
        @(posedge clk_i);
        #1;
        set_id(1, 1, 0, 1, 0, 5, 1, 1, 0);
        @(negedge clk_i);
        chk_all("reset_held", 0, 0, 0, 0);
        rst_i = 1'b1;
        issue(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk_all("post_reset_load", 0, 0, 1, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_all("post_reset_count", 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
